gpio_in_debounce: RTL
=====================

# gpio_in_debounce

Input-conditioning stage between the raw board switch/button pins and the SoC GPIO peripheral's `gpio_input` port on the BASYS3 top level. Per channel, it synchronises the asynchronous pin into `clk`, debounces it with a stable-count filter, and produces a clean level, one-cycle rise/fall pulses and a sticky event flag that software can clear. All channels are independent and identical.

## Interface

- `N_IN`, 2, number of input channels.
- `DEBOUNCE`, 1000000, consecutive stable cycles required to accept a new level (10 ms at 100 MHz); legal range ≥ 1.
- `CNT_W`, 20, counter width; must satisfy 2^CNT_W ≥ `DEBOUNCE`.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `pin_in`  in  N_IN  raw asynchronous pin levels.
- `level_out`  out  N_IN  debounced level; feeds `gpio_input`.
- `rise_out`  out  N_IN  one-cycle pulse on an accepted 0→1 change.
- `fall_out`  out  N_IN  one-cycle pulse on an accepted 1→0 change.
- `event_pending`  out  N_IN  sticky flag, set by any accepted change.
- `event_clr`  in  N_IN  per-channel clear of `event_pending`, sampled every cycle.

## Operation

- Synchroniser: two flip-flops per channel (`s1 <= pin_in`, `s2 <= s1`). Only `s2` is used downstream.
- Filter counter `cnt` (CNT_W bits) per channel:
  - If `s2 == level_out`: `cnt <= 0`.
  - If `s2 != level_out` and `cnt != DEBOUNCE-1`: `cnt <= cnt + 1`.
  - If `s2 != level_out` and `cnt == DEBOUNCE-1`: `level_out <= s2`, `cnt <= 0`, and assert `rise_out` (if `s2` = 1) or `fall_out` (if `s2` = 0) for that cycle.
- Any return of `s2` to the current level before acceptance discards the partial count. Glitches shorter than `DEBOUNCE` cycles are never propagated.
- `cnt` never exceeds `DEBOUNCE-1`, so no wrap-around can occur.
- `rise_out` and `fall_out` are registered. They are high only in the cycle immediately after the edge that updates `level_out`, and are never both high on the same channel.
- `event_pending`:
  - Set on the edge that asserts `rise_out` or `fall_out`.
  - Otherwise cleared when `event_clr` = 1.
  - Set has priority over a simultaneous clear.
  - Clearing an already-clear flag has no effect.
- Reset (`rst` = 1 at an edge): `s1`, `s2`, `cnt`, `level_out`, `rise_out`, `fall_out` and `event_pending` all become 0. Reset mid-count abandons the count. A pin held high through reset release is treated as a genuine 0→1 change and produces a rise after the normal latency.

## Timing

- Reset value of every output: 0.
- Latency: for a pin change set up before edge E, with the pin stable afterwards, `s2` changes after edge E+1. `level_out` and the pulse change after edge E+1+`DEBOUNCE`, so the total is `DEBOUNCE`+2 edges. With `DEBOUNCE` = 1, that is 3 edges.
- Pulse width: exactly 1 cycle. `event_pending` rises in the same cycle as the pulse.
- Clear: `event_clr` high at edge C drops `event_pending` after C, unless a pulse is being generated at C.
- Throughput: a new accepted change needs at least `DEBOUNCE` further stable cycles after the previous acceptance.

## Test plan

All scenarios use bench parameters `DEBOUNCE` = 4 and `N_IN` = 2.

1. Reset, then hold `pin_in` = 00 for 50 cycles → all outputs stay 0; no pulses.
2. Drive `pin_in[0]` 0→1 before edge E and hold it → `level_out[0]` = 1 after edge E+5. `rise_out[0]` is 1 for exactly that one cycle. `event_pending[0]` = 1 from that cycle. Channel 1 is unchanged.
3. Pulse `pin_in[1]` high for 3 cycles, then low → `level_out[1]`, `rise_out[1]` and `event_pending[1]` stay 0. A 4-cycle pulse (at `s2`) is accepted.
4. Bounce `pin_in[0]` 1,0,1,1,0,1 then hold 1 → exactly one `rise_out[0]` pulse, occurring 6 edges after the final transition. Then drive it low and hold → exactly one `fall_out[0]` pulse.
5. Hold `event_clr[0]` = 1 in the exact cycle a `fall_out[0]` is generated → `event_pending[0]` remains 1. Pulse `event_clr[0]` one cycle later → `event_pending[0]` = 0 on the next cycle.
6. Hold `pin_in` = 11 and assert `rst` for 1 cycle midway through a count → all state is 0 after the reset edge. Both channels then rise simultaneously, with `rise_out` = 11 in one cycle, 6 edges after reset release.

Source files
------------

// File: rtl/gpio_in_debounce.sv
// gpio_in_debounce
// Conditions raw board switch/button pins for the GPIO peripheral. Each channel
// is synchronised into clk, filtered by a stable-count debouncer, and produces a
// clean level, one-cycle rise/fall pulses and a software-clearable sticky flag.
// All channels are independent copies of the same logic.

module gpio_in_debounce #(
   parameter int N_IN     = 2,
   parameter int DEBOUNCE = 1000000,
   parameter int CNT_W    = 20
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_IN-1:0] pin_in,
   input  logic [N_IN-1:0] event_clr,
   output logic [N_IN-1:0] level_out,
   output logic [N_IN-1:0] rise_out,
   output logic [N_IN-1:0] fall_out,
   output logic [N_IN-1:0] event_pending
);

   // Terminal count: a change is accepted on the edge where the counter already
   // holds DEBOUNCE-1, which is the DEBOUNCE-th consecutive differing sample.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

   // Two-stage synchroniser registers, shared vector form across channels.
   logic [N_IN-1:0] s1;
   logic [N_IN-1:0] s2;

   // Bring the asynchronous pins into the clk domain; only s2 is used downstream.
   always_ff @(posedge clk) begin
      // NOTE: all clocked state uses non-blocking assignments so every register
      // samples the pre-edge values, which is what makes s1 -> s2 a real two-flop chain.
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= pin_in;
         s2 <= s1;
      end
   end

   for (genvar ch = 0; ch < N_IN; ch++) begin : g_ch

      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] cnt_nxt;
      logic             differs;
      logic             accept;

      // Decide, from the synchronised sample, whether to count, restart, or accept.
      always_comb begin
         // NOTE: every signal driven here gets a default first, so no path can
         // leave one unassigned and infer a latch.
         differs = (s2[ch] != level_out[ch]);
         accept  = 1'b0;
         cnt_nxt = '0;
         if (differs) begin
            if (cnt == CNT_LAST) begin
               accept = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
      end

      // Filter state: counter, accepted level, edge pulses and sticky event flag.
      always_ff @(posedge clk) begin
         if (rst) begin
            cnt                <= '0;
            level_out[ch]      <= 1'b0;
            rise_out[ch]       <= 1'b0;
            fall_out[ch]       <= 1'b0;
            event_pending[ch]  <= 1'b0;
         end else begin
            cnt           <= cnt_nxt;
            rise_out[ch]  <= accept &  s2[ch];
            fall_out[ch]  <= accept & ~s2[ch];
            if (accept) begin
               level_out[ch] <= s2[ch];
            end
            // A new acceptance wins over a clear arriving on the same edge.
            if (accept) begin
               event_pending[ch] <= 1'b1;
            end else if (event_clr[ch]) begin
               event_pending[ch] <= 1'b0;
            end
         end
      end

   end : g_ch

endmodule : gpio_in_debounce
